// File: rtl/uart_boot_loader_if.sv
// Word-wide memory write port driven by the UART boot loader.
// master: req/addr/wdata/strb out, gnt in; slave: the reverse.
`timescale 1ns/1ps
interface uart_boot_loader_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_strb,
    input  mem_gnt
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_strb,
    output mem_gnt
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: 8N1 receiver + frame FSM (len, addr, payload).
// Ports: g_clk, g_resetn, uart_rxd, mem (write master), busy, done, err.
`timescale 1ns/1ps
module uart_boot_loader #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BIT_RATE = 115200
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  uart_rxd,
  uart_boot_loader_if.master    mem,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int unsigned CPB  = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB + 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
  } rx_st_e;

  typedef enum logic [1:0] {
    S_LEN, S_ADDR, S_DATA, S_FLUSH
  } st_e;

  logic          sync1_q, sync2_q, prev_q;
  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          rxv_q, rxv_d;
  logic          ferr_q, ferr_d;
  logic          rx_start;

  st_e           st_q, st_d;
  logic [1:0]    bc_q, bc_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   ptr_q, ptr_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   buf_q, buf_d;
  logic [3:0]    bstrb_q, bstrb_d;
  logic          req_q, req_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [31:0]   nbuf, anew;
  logic [3:0]    nstrb;

  // Receiver
  always_comb begin
    rx_st_d  = rx_st_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    rxv_d    = 1'b0;
    ferr_d   = 1'b0;
    rx_start = 1'b0;
    unique case (rx_st_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) rx_st_d = R_START;
      end
      R_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          if (!sync2_q) begin
            rx_st_d  = R_DATA;
            bit_d    = 3'd0;
            rx_start = 1'b1;
          end else begin
            rx_st_d = R_IDLE;
          end
        end
      end
      R_DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          if (sync2_q) begin
            rxv_d   = 1'b1;
            rx_st_d = R_IDLE;
          end else begin
            ferr_d  = 1'b1;
            rx_st_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        cnt_d = '0;
        if (sync2_q) rx_st_d = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // Frame FSM and write stage
  always_comb begin
    st_d    = st_q;
    bc_d    = bc_q;
    len_d   = len_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    bstrb_d = bstrb_q;
    req_d   = req_q & ~mem.mem_gnt;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    done_d  = 1'b0;
    err_d   = err_q;
    busy_d  = busy_q | rx_start;
    anew    = {addr_q[23:0], sh_q};
    nbuf    = buf_q | ({24'b0, sh_q} << {lane_q, 3'b000});
    nstrb   = bstrb_q | (4'b0001 << lane_q);
    if (ferr_q) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
      st_d   = S_LEN;
      bc_d   = 2'd0;
    end else begin
      if (rxv_q) begin
        unique case (st_q)
          S_LEN: begin
            len_d = {len_q[23:0], sh_q};
            bc_d  = bc_q + 2'd1;
            if (bc_q == 2'd3) st_d = S_ADDR;
          end
          S_ADDR: begin
            addr_d = anew;
            bc_d   = bc_q + 2'd1;
            if (bc_q == 2'd3) begin
              if (len_q == 32'd0) begin
                done_d = 1'b1;
                busy_d = 1'b0;
                st_d   = S_LEN;
              end else begin
                ptr_d   = {anew[31:2], 2'b00};
                lane_d  = anew[1:0];
                buf_d   = '0;
                bstrb_d = '0;
                st_d    = S_DATA;
              end
            end
          end
          S_DATA: begin
            lane_d  = lane_q + 2'd1;
            len_d   = len_q - 32'd1;
            buf_d   = nbuf;
            bstrb_d = nstrb;
            if (lane_q == 2'd3 || len_q == 32'd1) begin
              buf_d   = '0;
              bstrb_d = '0;
              ptr_d   = ptr_q + 32'd4;
              // Previous word still pending: drop this one.
              if (req_q) begin
                err_d = 1'b1;
              end else begin
                req_d   = 1'b1;
                waddr_d = ptr_q;
                wdata_d = nbuf;
                wstrb_d = nstrb;
              end
            end
            if (len_q == 32'd1) st_d = S_FLUSH;
          end
          S_FLUSH: ;
          default: st_d = S_LEN;
        endcase
      end
      if (st_q == S_FLUSH && req_q && mem.mem_gnt) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        st_d   = S_LEN;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      rx_st_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rxv_q   <= 1'b0;
      ferr_q  <= 1'b0;
      st_q    <= S_LEN;
      bc_q    <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      ptr_q   <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      bstrb_q <= '0;
      req_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rxv_q   <= rxv_d;
      ferr_q  <= ferr_d;
      st_q    <= st_d;
      bc_q    <= bc_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      bstrb_q <= bstrb_d;
      req_q   <= req_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = waddr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_strb  = wstrb_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames plus random frames.
// Expected writes come from a byte-address grouping model.
`timescale 1ns/1ps
module tb_uart_boot_loader;
  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int unsigned BIT_RATE = 100_000;
  localparam int          CPB      = 10;
  localparam time         BIT_T    = 100;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;
  logic uart_rxd = 1'b1;
  logic busy, done, err;

  uart_boot_loader_if mem ();

  uart_boot_loader #(
    .CLK_HZ  (CLK_HZ),
    .BIT_RATE(BIT_RATE)
  ) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .uart_rxd(uart_rxd),
    .mem     (mem.master),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 g_clk = ~g_clk;

  int checks   = 0;
  int failures = 0;

  int done_cnt = 0;
  int busy_cnt = 0;
  always @(negedge g_clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  // Memory slave: grants after an optional stall, logs writes.
  int          stall_at = -1;
  int          wr_cnt   = 0;
  int          stab_err = 0;
  int          max_wait = 0;
  int          stall    = 0;
  int          wait_cyc = 0;
  bit          in_txn   = 1'b0;
  logic [67:0] cap;
  logic [67:0] wq[$];

  always @(negedge g_clk) begin
    if (mem.mem_req !== 1'b1) begin
      mem.mem_gnt = 1'b0;
      in_txn      = 1'b0;
    end else begin
      if (!in_txn || mem.mem_gnt === 1'b1) begin
        in_txn   = 1'b1;
        cap      = {mem.mem_addr, mem.mem_wdata, mem.mem_strb};
        stall    = (wr_cnt == stall_at) ? 3 * CPB : 0;
        wait_cyc = 0;
      end else if (cap !== {mem.mem_addr, mem.mem_wdata,
                            mem.mem_strb}) begin
        stab_err++;
      end
      if (stall > 0) begin
        stall--;
        wait_cyc++;
        mem.mem_gnt = 1'b0;
      end else begin
        mem.mem_gnt = 1'b1;
        wq.push_back({mem.mem_addr, mem.mem_wdata, mem.mem_strb});
        wr_cnt++;
        if (wait_cyc > max_wait) max_wait = wait_cyc;
      end
    end
  end

  logic [7:0]  pl[$];
  logic [67:0] exp_q[$];

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Each payload byte lands at byte address addr+i; consecutive
  // bytes sharing a word form one write.
  task automatic model(input logic [31:0] len, input logic [31:0] addr);
    logic [31:0] cw, a, w, data;
    logic [3:0]  strb;
    exp_q.delete();
    cw   = {addr[31:2], 2'b00};
    data = '0;
    strb = '0;
    for (int unsigned i = 0; i < len; i++) begin
      a = addr + i;
      w = {a[31:2], 2'b00};
      if (strb != 4'h0 && w != cw) begin
        exp_q.push_back({cw, data, strb});
        data = '0;
        strb = '0;
      end
      cw = w;
      data[8*a[1:0] +: 8] = pl[i];
      strb[a[1:0]] = 1'b1;
    end
    if (strb != 4'h0) exp_q.push_back({cw, data, strb});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rxd = 1'b0;
    #BIT_T;
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      #BIT_T;
    end
    uart_rxd = !bad_stop;
    #BIT_T;
    uart_rxd = 1'b1;
  endtask

  task automatic send_hdr(input logic [31:0] len, input logic [31:0] addr);
    for (int i = 3; i >= 0; i--) send_byte(len[8*i +: 8], 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8], 1'b0);
  endtask

  task automatic run_frame(input logic [31:0] len, input logic [31:0] addr,
                           input string tag);
    int bw, bd, n;
    bw = wq.size();
    bd = done_cnt;
    send_hdr(len, addr);
    foreach (pl[i]) send_byte(pl[i], 1'b0);
    n = 0;
    while (done_cnt == bd && n < 3000) begin
      @(negedge g_clk);
      n++;
    end
    repeat (20) @(negedge g_clk);
    chk({tag, "_done"}, 72'(done_cnt - bd), 72'd1);
    chk({tag, "_busy"}, 72'(busy), 72'd0);
    model(len, addr);
    chk({tag, "_nwr"}, 72'(wq.size() - bw), 72'(exp_q.size()));
    foreach (exp_q[i])
      if (bw + i < wq.size())
        chk($sformatf("%s_wr%0d", tag, i), 72'(wq[bw + i]),
            72'(exp_q[i]));
  endtask

  task automatic fill_seq(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(i));
  endtask

  task automatic fill_t2();
    pl.delete();
    pl.push_back(8'h11);
    pl.push_back(8'h22);
    pl.push_back(8'h33);
    pl.push_back(8'h44);
    pl.push_back(8'h55);
  endtask

  initial begin
    int b, bb;
    logic [31:0] ra;
    int rl;

    repeat (5) @(negedge g_clk);
    chk("reset_out", {mem.mem_req, mem.mem_addr, mem.mem_wdata,
                      mem.mem_strb, busy, done, err}, 72'd0);
    g_resetn = 1'b1;
    #(2 * BIT_T);

    // T1: 112-byte aligned load
    fill_seq(112);
    b = wq.size();
    run_frame(32'h70, 32'h0001_0000, "t1");
    if (wq.size() > b)
      chk("t1_first", 72'(wq[b]),
          72'({32'h0001_0000, 32'h0302_0100, 4'hF}));
    chk("t1_err", 72'(err), 72'd0);

    // T3: zero-length frame
    pl.delete();
    run_frame(32'h0, 32'h20, "t3");

    // T5: short glitch on the idle line
    bb = busy_cnt;
    b  = wq.size();
    @(negedge g_clk);
    uart_rxd = 1'b0;
    #25;
    uart_rxd = 1'b1;
    #(3 * BIT_T);
    chk("t5_busy", 72'(busy_cnt - bb), 72'd0);
    chk("t5_nwr", 72'(wq.size() - b), 72'd0);

    // T2: unaligned 5-byte load
    fill_t2();
    b = wq.size();
    run_frame(32'd5, 32'h0000_0102, "t2");
    if (wq.size() > b + 1) begin
      chk("t2_w0", 72'(wq[b]), 72'({32'h100, 32'h2211_0000, 4'hC}));
      chk("t2_w1", 72'(wq[b + 1]), 72'({32'h104, 32'h0055_4433, 4'h7}));
    end

    // T4: framing error in the length field
    b = wq.size();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    #(3 * BIT_T);
    chk("t4_err", 72'(err), 72'd1);
    chk("t4_busy", 72'(busy), 72'd0);
    chk("t4_nwr", 72'(wq.size() - b), 72'd0);
    fill_t2();
    run_frame(32'd5, 32'h0000_0102, "t4_t2");
    chk("t4_err_sticky", 72'(err), 72'd1);

    // T6: reset in the middle of a payload
    fill_seq(112);
    send_hdr(32'h70, 32'h0001_0000);
    for (int i = 0; i < 10; i++) send_byte(pl[i], 1'b0);
    chk("t6_busy_mid", 72'(busy), 72'd1);
    #3 g_resetn = 1'b0;
    #1;
    chk("t6_rst_out", {mem.mem_req, mem.mem_addr, mem.mem_wdata,
                       mem.mem_strb, busy, done, err}, 72'd0);
    repeat (5) @(negedge g_clk);
    g_resetn = 1'b1;
    #(2 * BIT_T);
    fill_t2();
    run_frame(32'd5, 32'h0000_0102, "t6_t2");
    chk("t6_err", 72'(err), 72'd0);

    // T7: stalled grant on the first word
    stall_at = wr_cnt;
    fill_seq(112);
    run_frame(32'h70, 32'h0001_0000, "t7");
    chk("t7_err", 72'(err), 72'd0);
    chk("t7_stable", 72'(stab_err), 72'd0);
    chk("t7_stalled", 72'(max_wait >= 3 * CPB), 72'd1);

    // Address wrap across 2^32
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    run_frame(32'd6, 32'hFFFF_FFFD, "wrap");

    // Random frames
    for (int f = 0; f < 3; f++) begin
      rl = $urandom_range(1, 12);
      ra = $urandom;
      pl.delete();
      for (int i = 0; i < rl; i++) pl.push_back(8'($urandom));
      run_frame(32'(rl), ra, $sformatf("rnd%0d", f));
    end
    chk("final_err", 72'(err), 72'd0);
    chk("final_stable", 72'(stab_err), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
